// File: rtl/bu_pkg.sv
// Shared types and elaboration-time helpers for the modular butterfly datapath.
package bu_pkg;

    typedef enum logic [1:0] {
        BU_CT   = 2'b00,
        BU_GS   = 2'b01,
        BU_PASS = 2'b10,
        BU_RSVD = 2'b11
    } bu_mode_e;

    localparam int unsigned BU_Q_DEFAULT = 8380417;

    // Barrett constant MU = floor(2^(2K) / Q) with K = clog2(Q).
    function automatic logic [65:0] bu_calc_mu(input logic [63:0] q);
        logic [65:0] num;
        num = 66'd1 << (2 * $clog2(q));
        return num / {2'b00, q};
    endfunction

endpackage

// File: rtl/bu_mod_pipe_if.sv
// Upstream operation bus and downstream result bus of the butterfly, bundled as one interface.
interface bu_mod_pipe_if
    import bu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 8
);
    logic             valid_i;
    logic             ready_o;
    bu_mode_e         mode_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] w_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] x_o;
    logic [WIDTH-1:0] y_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output valid_i, mode_i, a_i, b_i, w_i, tag_i, ready_i,
        input  ready_o, valid_o, x_o, y_o, tag_o
    );

    modport slave (
        input  valid_i, mode_i, a_i, b_i, w_i, tag_i, ready_i,
        output ready_o, valid_o, x_o, y_o, tag_o
    );
endinterface

// File: rtl/barrett_reduce.sv
// Two-stage Barrett reducer: stage 1 registers p and the quotient estimate, stage 2 the remainder in [0, Q).
module barrett_reduce
    import bu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned Q     = BU_Q_DEFAULT,
    localparam int         K     = $clog2(Q)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [2*K-1:0]   p_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] r_o
);
    localparam logic [65:0] MU_FULL = bu_calc_mu(64'(Q));
    localparam logic [K:0]  MU      = MU_FULL[K:0];

    logic [K:0]   p_hi;
    logic [K:0]   qh_next;
    logic [K+1:0] p_lo_reg;
    logic [K:0]   qh_reg;
    logic         s3_valid_reg;
    logic [K+1:0] r_raw;
    logic [K+1:0] r_one;
    logic [K+1:0] r_two;
    logic [WIDTH-1:0] r_reg;
    logic         s4_valid_reg;

    assign p_hi    = p_i[2*K-1:K-1];
    assign qh_next = (K+1)'(((2*K+2)'(p_hi) * (2*K+2)'(MU)) >> (K+1));

    // The remainder is below 3Q < 2^(K+2), so only the low K+2 bits of p matter.
    assign r_raw = p_lo_reg - (K+2)'((K+2)'(qh_reg) * (K+2)'(Q));
    assign r_one = (r_raw >= (K+2)'(Q)) ? r_raw - (K+2)'(Q) : r_raw;
    assign r_two = (r_one >= (K+2)'(Q)) ? r_one - (K+2)'(Q) : r_one;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s3_valid_reg <= 1'b0;
            p_lo_reg     <= '0;
            qh_reg       <= '0;
            s4_valid_reg <= 1'b0;
            r_reg        <= '0;
        end else if (en_i) begin
            s3_valid_reg <= valid_i;
            p_lo_reg     <= p_i[K+1:0];
            qh_reg       <= qh_next;
            s4_valid_reg <= s3_valid_reg;
            r_reg        <= WIDTH'(r_two);
        end
    end

    assign valid_o = s4_valid_reg;
    assign r_o     = r_reg;

endmodule

// File: rtl/bu_mod_pipe.sv
// Pipelined modular butterfly (CT / GS / pass-through) with fully reduced results in [0, Q).
// Five register stages share one stall enable; mode and tag ride alongside the data.
module bu_mod_pipe
    import bu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned Q     = BU_Q_DEFAULT,
    parameter int unsigned TAG_W = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    bu_mod_pipe_if.slave bus
);
    localparam int K = $clog2(Q);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] w;
        bu_mode_e         mode;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] xs;
        bu_mode_e         mode;
        logic [TAG_W-1:0] tag;
    } side_t;

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= (WIDTH+1)'(Q)) s = s - (WIDTH+1)'(Q);
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return (x < y) ? (x - y + WIDTH'(Q)) : (x - y);
    endfunction

    logic             adv;
    logic             s1_valid_reg;
    s1_t              s1_reg;
    logic             s2_valid_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] w_reg;
    side_t            side2_reg;
    side_t            side_dly_reg [2];
    logic [WIDTH-1:0] m_next;
    logic [2*K-1:0]   p_comb;
    logic             s4_valid;
    logic [WIDTH-1:0] r_val;
    logic             valid_o_reg;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [TAG_W-1:0] tag_reg;

    assign adv         = !valid_o_reg || bus.ready_i;
    assign bus.ready_o = adv;
    assign bus.valid_o = valid_o_reg;
    assign bus.x_o     = x_reg;
    assign bus.y_o     = y_reg;
    assign bus.tag_o   = tag_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid_reg <= 1'b0;
            s1_reg       <= '0;
        end else if (adv) begin
            s1_valid_reg <= bus.valid_i;
            s1_reg.a     <= bus.a_i;
            s1_reg.b     <= bus.b_i;
            s1_reg.w     <= bus.w_i;
            s1_reg.mode  <= bus.mode_i;
            s1_reg.tag   <= bus.tag_i;
        end
    end

    // GS multiplies the reduced difference by w; CT (and the ignored PASS product) use b.
    always_comb begin
        m_next = s1_reg.b;
        if (s1_reg.mode == BU_GS) m_next = mod_sub(s1_reg.a, s1_reg.b);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s2_valid_reg <= 1'b0;
            m_reg        <= '0;
            w_reg        <= '0;
            side2_reg    <= '0;
        end else if (adv) begin
            s2_valid_reg   <= s1_valid_reg;
            m_reg          <= m_next;
            w_reg          <= s1_reg.w;
            side2_reg.a    <= s1_reg.a;
            side2_reg.b    <= s1_reg.b;
            side2_reg.xs   <= mod_add(s1_reg.a, s1_reg.b);
            side2_reg.mode <= s1_reg.mode;
            side2_reg.tag  <= s1_reg.tag;
        end
    end

    assign p_comb = (2*K)'(m_reg) * (2*K)'(w_reg);

    barrett_reduce #(
        .WIDTH (WIDTH),
        .Q     (Q)
    ) u_barrett (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .en_i    (adv),
        .valid_i (s2_valid_reg),
        .p_i     (p_comb),
        .valid_o (s4_valid),
        .r_o     (r_val)
    );

    // Sideband delay line matching the two reducer stages.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 2; i++) side_dly_reg[i] <= '0;
        end else if (adv) begin
            side_dly_reg[0] <= side2_reg;
            side_dly_reg[1] <= side_dly_reg[0];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_o_reg <= 1'b0;
            x_reg       <= '0;
            y_reg       <= '0;
            tag_reg     <= '0;
        end else if (adv) begin
            valid_o_reg <= s4_valid;
            if (s4_valid) begin
                tag_reg <= side_dly_reg[1].tag;
                case (side_dly_reg[1].mode)
                    BU_CT: begin
                        x_reg <= mod_add(side_dly_reg[1].a, r_val);
                        y_reg <= mod_sub(side_dly_reg[1].a, r_val);
                    end
                    BU_GS: begin
                        x_reg <= side_dly_reg[1].xs;
                        y_reg <= r_val;
                    end
                    default: begin
                        x_reg <= side_dly_reg[1].a;
                        y_reg <= side_dly_reg[1].b;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bu_mod_pipe.sv
// Directed bench for bu_mod_pipe with a scoreboard queue of expected results.
module tb_bu_mod_pipe;
    import bu_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned Q     = 8380417;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b1;
    int   cyc    = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    bu_mod_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    bu_mod_pipe #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  tag;
        int          stamp;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    int          n_vec   = 0;
    int          n_err   = 0;
    bit          in_took = 1'b0;
    bit          lat_chk = 1'b0;
    logic [31:0] pend_x  = '0;
    logic [31:0] pend_y  = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void model(input bu_mode_e m, input longint unsigned a, input longint unsigned b,
                                  input longint unsigned w, output logic [31:0] x, output logic [31:0] y);
        longint unsigned q;
        longint unsigned t;
        q = Q;
        case (m)
            BU_CT: begin
                t = (b * w) % q;
                x = 32'((a + t) % q);
                y = 32'((a + q - t) % q);
            end
            BU_GS: begin
                x = 32'((a + b) % q);
                y = 32'((((a + q - b) % q) * w) % q);
            end
            default: begin
                x = 32'(a);
                y = 32'(b);
            end
        endcase
    endfunction

    // One clock: check outputs at the falling edge, record any input transfer, return just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk_i);
        in_took = bus.valid_i && bus.ready_o;
        if (bus.valid_o) begin
            if (sb.size() == 0) begin
                chk("spurious_valid_o", 32'(bus.valid_o), 32'd0);
            end else begin
                e = sb[0];
                chk("x_o", bus.x_o, e.x);
                chk("y_o", bus.y_o, e.y);
                chk("tag_o", 32'(bus.tag_o), 32'(e.tag));
                if (bus.ready_i) begin
                    if (e.chk_lat) chk("latency", 32'(cyc - e.stamp), 32'd5);
                    void'(sb.pop_front());
                end else begin
                    chk("stall_ready_o", 32'(bus.ready_o), 32'd0);
                end
            end
        end else begin
            chk("idle_ready_o", 32'(bus.ready_o), 32'd1);
        end
        if (in_took) sb.push_back('{pend_x, pend_y, bus.tag_i, cyc, lat_chk});
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input bu_mode_e m, input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                        input logic [7:0] t, input logic [31:0] ex, input logic [31:0] ey);
        bit took;
        took = 1'b0;
        bus.valid_i = 1'b1;
        bus.mode_i  = m;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.w_i     = w;
        bus.tag_i   = t;
        pend_x      = ex;
        pend_y      = ey;
        for (int i = 0; i < 20 && !took; i++) begin
            cycle();
            took = in_took;
        end
        if (!took) chk("accept_timeout", 32'(took), 32'd1);
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) cycle();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] ex;
        logic [31:0] ey;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rw;
        bu_mode_e    m;
        int          idx;
        int          stall_left;
        bit          started;

        bus.valid_i = 1'b0;
        bus.mode_i  = BU_CT;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.w_i     = '0;
        bus.tag_i   = '0;
        bus.ready_i = 1'b1;

        // Reset state
        #2 rstn_i = 1'b0;
        #1;
        chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
        chk("rst_x_o", bus.x_o, 32'd0);
        chk("rst_y_o", bus.y_o, 32'd0);
        chk("rst_tag_o", 32'(bus.tag_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        chk("rst_ready_o", 32'(bus.ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        // Directed single operations with latency checking
        lat_chk = 1'b1;
        send(BU_CT, 32'd5, 32'd3, 32'd7, 8'h11, 32'd26, 32'd8380401);
        drain();
        send(BU_GS, 32'd3, 32'd5, 32'd2, 8'h21, 32'd8, 32'd8380413);
        send(BU_GS, 32'd5, 32'd3, 32'd7, 8'h22, 32'd8, 32'd14);
        drain();
        send(BU_CT, 32'd8380416, 32'd8380416, 32'd8380416, 8'h31, 32'd0, 32'd8380415);
        drain();
        send(BU_PASS, 32'd123, 32'd456, 32'd9, 8'h41, 32'd123, 32'd456);
        send(BU_RSVD, 32'd123, 32'd456, 32'd9, 8'h42, 32'd123, 32'd456);
        drain();

        // Mixed-mode stream with a 3-cycle downstream stall at the first result
        lat_chk    = 1'b0;
        idx        = 0;
        stall_left = 3;
        started    = 1'b0;
        for (int g = 0; g < 100 && idx < 8; g++) begin
            m  = bu_mode_e'(2'(idx % 4));
            ra = (idx == 0) ? 32'd0 : 32'($urandom_range(0, Q - 1));
            rb = (idx == 1) ? 32'(Q - 1) : 32'($urandom_range(0, Q - 1));
            rw = 32'($urandom_range(0, Q - 1));
            model(m, longint'(ra), longint'(rb), longint'(rw), ex, ey);
            bus.valid_i = 1'b1;
            bus.mode_i  = m;
            bus.a_i     = ra;
            bus.b_i     = rb;
            bus.w_i     = rw;
            bus.tag_i   = 8'(idx);
            pend_x      = ex;
            pend_y      = ey;
            if (bus.valid_o) started = 1'b1;
            bus.ready_i = !(started && stall_left > 0);
            if (started && stall_left > 0) stall_left--;
            cycle();
            if (in_took) idx++;
        end
        chk("stream_accepted", 32'(idx), 32'd8);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        drain();

        // Reset with operations in flight
        for (int i = 0; i < 3; i++) begin
            model(BU_CT, longint'(10 + i), longint'(20 + i), 64'd3, ex, ey);
            send(BU_CT, 32'(10 + i), 32'(20 + i), 32'd3, 8'(8'h60 + i), ex, ey);
        end
        rstn_i = 1'b0;
        #1;
        chk("midrst_valid_o", 32'(bus.valid_o), 32'd0);
        chk("midrst_x_o", bus.x_o, 32'd0);
        chk("midrst_y_o", bus.y_o, 32'd0);
        chk("midrst_tag_o", 32'(bus.tag_o), 32'd0);
        sb.delete();
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 8; i++) cycle();
        lat_chk = 1'b1;
        send(BU_GS, 32'd5, 32'd3, 32'd7, 8'h55, 32'd8, 32'd14);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bu_mod_pipe.md
# bu_mod_pipe

Pipelined, parametrised modular butterfly unit for the NTT/INTT datapath, successor to the unreduced single-stage butterfly. Per operation it selects Cooley-Tukey (CT), Gentleman-Sande (GS) or pass-through mode. Results are fully reduced into [0, Q) using a built-in Barrett reducer. It sits between the NTT address/twiddle controller and the coefficient memory write port, with a valid/ready handshake on both sides and a tag sideband that carries the write address.

## Interface
Parameters:
- WIDTH, 32, coefficient and twiddle width; must satisfy WIDTH ≥ K.
- Q, 8380417, modulus; odd, Q < 2^WIDTH.
- TAG_W, 8, width of the opaque sideband tag.

Ports:
- clk_i  in  1  single clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input operation valid.
- ready_o  out  1  unit can accept an input this cycle.
- mode_i  in  2  operation mode: 00 CT, 01 GS, 10 PASS, 11 treated as PASS.
- a_i  in  WIDTH  operand a, in range [0, Q).
- b_i  in  WIDTH  operand b, in range [0, Q).
- w_i  in  WIDTH  twiddle factor, in range [0, Q).
- tag_i  in  TAG_W  sideband tag, returned unchanged.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- x_o  out  WIDTH  result x.
- y_o  out  WIDTH  result y.
- tag_o  out  TAG_W  tag of the current result.

## Operation
- Definitions: K = $clog2(Q); MU = floor(2^(2K) / Q), computed at elaboration.
- CT mode: t = b·w mod Q; x = (a + t) mod Q; y = (a − t) mod Q.
- GS mode: x = (a + b) mod Q; y = ((a − b) mod Q)·w mod Q.
- PASS mode: x = a, y = b, with no reduction.
- Modular add: s = a + b computed at WIDTH+1 bits; subtract Q if s ≥ Q.
- Modular subtract: d = a − b; add Q if a < b.
- Barrett reduction of a product p (2·WIDTH bits, p < Q²):
  - qh = ((p >> (K−1)) · MU) >> (K+1);
  - r = p − qh·Q;
  - up to two conditional subtractions of Q, so that r ∈ [0, Q).
- Pipeline stages, each with a valid bit; mode and tag travel with the data:
  - S1: capture a, b, w, mode, tag.
  - S2: form the product input. CT uses p = b·w. GS uses p = ((a − b) mod Q)·w, and registers xs = (a + b) mod Q.
  - S3: register p and qh.
  - S4: register r.
  - S5: output register. CT: x = (a + r) mod Q, y = (a − r) mod Q. GS: x = xs, y = r. PASS: x = a, y = b.
- Out-of-range operands: outputs are unspecified, but the handshake and tag are still correct.

## Timing
- Stall control: the pipeline advances when adv = !valid_o || ready_i. All stages stall together.
- ready_o = adv. An input transfer occurs when valid_i && ready_o.
- Latency: exactly 5 clock edges from transfer to valid_o, with no stalls.
- Throughput: one operation per cycle while ready_i is held high.
- Hold rule: while valid_o && !ready_i, x_o, y_o, tag_o and valid_o hold stable.
- Ordering: results emerge in input order. Mixed modes back-to-back are legal and need no bubbles.
- Bubbles (valid_i low) propagate as invalid slots. No bubble collapsing is required.
- Reset values: every stage valid bit = 0; valid_o = 0, x_o = 0, y_o = 0, tag_o = 0; ready_o = 1 once rstn_i is high.
- Reset mid-operation: all in-flight operations are discarded immediately (asynchronous). No stale result appears after release.
- Simultaneous output and input transfer in the same cycle is legal; there is no loss and no duplication.

## Structure
- Package bu_pkg holds:
  - the mode typedef enum logic [1:0] {BU_CT, BU_GS, BU_PASS, BU_RSVD};
  - the default Q;
  - a function computing MU from Q.
- Sub-module barrett_reduce (parameters WIDTH and Q):
  - 2-stage register slice with a stall enable and a valid bit;
  - instantiated once, covering S3–S4.
- Modular add/sub: local functions, not separate modules.

## Test plan
All scenarios use Q = 8380417, WIDTH = 32, ready_i = 1 unless stated.
- CT, a=5, b=3, w=7, tag=0x11 → after 5 cycles x=26, y=8380401, tag_o=0x11.
- GS, a=3, b=5, w=2 → x=8, y=8380413. GS, a=5, b=3, w=7 → x=8, y=14.
- CT, a=b=w=8380416 (Q−1) → x=0, y=8380415. Exercises the Barrett correction path and the maximum product.
- Stream of 8 mixed-mode operations, tags 0..7; ready_i low for 3 cycles starting at the first valid_o:
  - outputs held stable during the stall;
  - ready_o low during the stall;
  - all 8 results correct and in tag order.
- PASS, a=123, b=456 → x=123, y=456. Mode 11 gives an identical result.
- 3 operations in flight, then rstn_i pulsed low for 1 cycle → valid_o=0 and all outputs 0 immediately. After release, no result appears until a new input is accepted; that new input's result arrives 5 cycles later.
